// File: rtl/qrd_seq_ctrl.sv
// Sequencer for the 4x4 complex QRD systolic core: buffers one [H | y], feeds skewed rows, captures R/QHy, streams results.
// Optional sticky capture-error check is built only when QRD_SEQ_ERRCHK_EN is defined.
module qrd_seq_ctrl #(
    parameter int W       = 14,
    parameter int CAP_OFS = 5,
    parameter int NSLOT   = CAP_OFS + 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [W-1:0]   load_r,
    input  logic [W-1:0]   load_i,
    input  logic           qrd_in_ready,
    input  logic           qrd_out_valid,
    output logic [4*W-1:0] row_in_r,
    output logic [4*W-1:0] row_in_i,
    output logic [2:0]     row_in_f,
    input  logic [4*W-1:0] row_out_r,
    input  logic [4*W-1:0] row_out_i,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_r,
    output logic [W-1:0]   res_i,
    output logic           busy,
    output logic           err
);

    localparam int NWORD = 20;
    localparam int SW    = $clog2(NSLOT);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FEED,
        ST_UNLOAD
    } state_t;

    state_t state, state_nxt;

    logic [4:0]    idx;
    logic [SW-1:0] slot;
    logic [SW-1:0] nxt_slot;

    logic [W-1:0] in_buf_r  [NWORD];
    logic [W-1:0] in_buf_i  [NWORD];
    logic [W-1:0] res_buf_r [NWORD];
    logic [W-1:0] res_buf_i [NWORD];

    logic [4*W-1:0] feed_r, feed_i;
    logic [2:0]     feed_f;

    logic load_hs, res_hs, consume, last_idx, last_slot;

    assign load_hs   = (state == ST_LOAD) && load_valid;
    assign res_hs    = (state == ST_UNLOAD) && res_ready;
    assign consume   = (state == ST_FEED) && qrd_in_ready;
    assign last_idx  = (idx == 5'(NWORD - 1));
    assign last_slot = (slot == SW'(NSLOT - 1));

    assign load_ready = (state == ST_LOAD);
    assign res_valid  = (state == ST_UNLOAD);
    assign busy       = (state != ST_LOAD);
    assign res_r      = res_buf_r[idx];
    assign res_i      = res_buf_i[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:   if (load_hs && last_idx)   state_nxt = ST_FEED;
            ST_FEED:   if (consume && last_slot)  state_nxt = ST_UNLOAD;
            ST_UNLOAD: if (res_hs && last_idx)    state_nxt = ST_LOAD;
            default:                              state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            slot <= '0;
        end else begin
            if (load_hs || res_hs)
                idx <= last_idx ? 5'd0 : idx + 5'd1;
            if (consume)
                slot <= last_slot ? '0 : slot + SW'(1);
        end
    end

    // Outputs are registered, so build the slot that will be presented after this edge.
    assign nxt_slot = (state == ST_FEED) ? slot + SW'(1) : '0;

    always_comb begin
        feed_r = '0;
        feed_i = '0;
        feed_f = '0;
        for (int k = 0; k < 4; k++) begin
            if (nxt_slot >= SW'(k) && nxt_slot <= SW'(k + 4)) begin
                feed_r[k*W +: W] = in_buf_r[5'(k*5) + 5'(nxt_slot) - 5'(k)];
                feed_i[k*W +: W] = in_buf_i[5'(k*5) + 5'(nxt_slot) - 5'(k)];
            end
        end
        for (int k = 0; k < 3; k++)
            feed_f[k] = (nxt_slot == SW'(2*k));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_in_r <= '0;
            row_in_i <= '0;
            row_in_f <= '0;
        end else if ((load_hs && last_idx) || (consume && !last_slot)) begin
            row_in_r <= feed_r;
            row_in_i <= feed_i;
            row_in_f <= feed_f;
        end else if (consume) begin
            row_in_r <= '0;
            row_in_i <= '0;
            row_in_f <= '0;
        end
    end

    // Matrix and result storage carry no reset; a fresh load/feed overwrites every entry.
    always_ff @(posedge clk) begin
        if (load_hs) begin
            in_buf_r[idx] <= load_r;
            in_buf_i[idx] <= load_i;
        end
        if (consume && qrd_out_valid) begin
            for (int k = 0; k < 4; k++) begin
                if (slot >= SW'(CAP_OFS + k) && slot <= SW'(CAP_OFS + k + 4)) begin
                    res_buf_r[5'(k*5) + 5'(slot) - 5'(CAP_OFS + k)] <= row_out_r[k*W +: W];
                    res_buf_i[5'(k*5) + 5'(slot) - 5'(CAP_OFS + k)] <= row_out_i[k*W +: W];
                end
            end
        end
    end

`ifdef QRD_SEQ_ERRCHK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if ((consume && slot >= SW'(CAP_OFS) && !qrd_out_valid) ||
                 ((state == ST_FEED) && qrd_out_valid && slot < SW'(CAP_OFS)))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_qrd_seq_ctrl.sv
// Randomized scoreboard bench for qrd_seq_ctrl: reference model of buffering, skew, capture and streaming.
module tb_qrd_seq_ctrl;
    localparam int W       = 14;
    localparam int CAP_OFS = 5;
    localparam int NSLOT   = CAP_OFS + 8;
`ifdef QRD_SEQ_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           load_valid;
    logic           load_ready;
    logic [W-1:0]   load_r, load_i;
    logic           qrd_in_ready, qrd_out_valid;
    logic [4*W-1:0] row_in_r, row_in_i;
    logic [2:0]     row_in_f;
    logic [4*W-1:0] row_out_r, row_out_i;
    logic           res_valid, res_ready;
    logic [W-1:0]   res_r, res_i;
    logic           busy, err;

    qrd_seq_ctrl #(.W(W), .CAP_OFS(CAP_OFS)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_r(load_r), .load_i(load_i),
        .qrd_in_ready(qrd_in_ready), .qrd_out_valid(qrd_out_valid),
        .row_in_r(row_in_r), .row_in_i(row_in_i), .row_in_f(row_in_f),
        .row_out_r(row_out_r), .row_out_i(row_out_i),
        .res_valid(res_valid), .res_ready(res_ready), .res_r(res_r), .res_i(res_i),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]   d_r [20];
    logic [W-1:0]   d_i [20];
    logic [2*W-1:0] res_m [20];
    logic [2*W-1:0] exp_q [$];
    logic           err_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result beat is compared against the scoreboard head.
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL res_extra: beat %0h with nothing expected", {res_r, res_i});
                end else begin
                    e = exp_q.pop_front();
                    chk("res_word", {res_r, res_i}, e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_reset_state();
        chk("rst_load_ready", load_ready, 1);
        chk("rst_row_r", row_in_r, 0);
        chk("rst_row_i", row_in_i, 0);
        chk("rst_row_f", row_in_f, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
    endtask

    // Called at a negedge; returns aligned to posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        qrd_in_ready = 1'b0;
        qrd_out_valid = 1'b0;
        load_valid = 1'b0;
        res_ready = 1'b0;
        err_m = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // dmode 0: word n = (n,-n); smode 0 none / 1 three stalls at s=6 / 2 random;
    // omode 0: row_out[k] = (100(k+1)+s, negated); rmode 0: res_ready 1010..
    task automatic run_matrix(input int dmode, input int smode, input int omode, input int rmode,
                              input int rst_slot, input int err_slot, input bit gaps);
        int cnt, cyc, s, stalls, c;
        bit ov, tog;
        logic [W-1:0]   v;
        logic [4*W-1:0] er, ei;
        logic [2:0]     ef;

        for (int n = 0; n < 20; n++) begin
            d_r[n] = (dmode == 0) ? W'(n)  : W'($urandom);
            d_i[n] = (dmode == 0) ? W'(-n) : W'($urandom);
        end

        cnt = 0; cyc = 0;
        while (cnt < 20 && cyc < 500) begin
            cyc++;
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_r = d_r[cnt];
            load_i = d_i[cnt];
            @(negedge clk);
            chk("load_ready", load_ready, 1);
            chk("load_busy", busy, 0);
            @(posedge clk);
            if (load_valid) cnt++;
            #1;
        end
        load_valid = 1'b0;
        if (cnt < 20) chk("load_timeout", cnt, 20);

        s = 0; cyc = 0; stalls = 0;
        while (s < NSLOT && cyc < 300) begin
            cyc++;
            case (smode)
                0:       qrd_in_ready = 1'b1;
                1:       qrd_in_ready = !(s == 6 && stalls < 3);
                default: qrd_in_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (!qrd_in_ready) stalls++;
            ov = (s >= CAP_OFS) && (s != err_slot);
            qrd_out_valid = ov;
            for (int k = 0; k < 4; k++) begin
                v = (omode == 0) ? W'(100 * (k + 1) + s) : W'($urandom);
                row_out_r[k*W +: W] = v;
                row_out_i[k*W +: W] = (omode == 0) ? -v : W'($urandom);
            end
            er = '0; ei = '0; ef = '0;
            for (int k = 0; k < 4; k++) begin
                if (s >= k && s <= k + 4) begin
                    er[k*W +: W] = d_r[k*5 + s - k];
                    ei[k*W +: W] = d_i[k*5 + s - k];
                end
            end
            for (int k = 0; k < 3; k++) ef[k] = (s == 2 * k);
            @(negedge clk);
            chk("feed_row_r", row_in_r, er);
            chk("feed_row_i", row_in_i, ei);
            chk("feed_row_f", row_in_f, ef);
            chk("feed_busy", busy, 1);
            chk("feed_load_ready", load_ready, 0);
            chk("feed_res_valid", res_valid, 0);
            chk("feed_err", err, err_m);
            if (s == rst_slot) begin
                do_reset();
                return;
            end
            @(posedge clk);
            if (qrd_in_ready) begin
                if (!ov && s >= CAP_OFS && ERRCHK) err_m = 1'b1;
                if (ov) begin
                    for (int k = 0; k < 4; k++) begin
                        c = s - CAP_OFS - k;
                        if (c >= 0 && c <= 4)
                            res_m[k*5 + c] = {row_out_r[k*W +: W], row_out_i[k*W +: W]};
                    end
                end
                s++;
            end
            #1;
        end
        qrd_in_ready = 1'b0;
        qrd_out_valid = 1'b0;
        if (s < NSLOT) chk("feed_timeout", s, NSLOT);

        for (int n = 0; n < 20; n++) exp_q.push_back(res_m[n]);
        cnt = 0; cyc = 0; tog = 1'b1;
        while (cnt < 20 && cyc < 400) begin
            cyc++;
            res_ready = (rmode == 0) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            @(negedge clk);
            chk("unl_res_valid", res_valid, 1);
            chk("unl_load_ready", load_ready, 0);
            chk("unl_row_r", row_in_r, 0);
            chk("unl_err", err, err_m);
            if (res_valid && res_ready) cnt++;
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        chk("unl_beats", cnt, 20);
        @(negedge clk);
        chk("post_load_ready", load_ready, 1);
        chk("post_res_valid", res_valid, 0);
        chk("post_err", err, err_m);
        chk("sb_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        load_valid = 1'b0; load_r = '0; load_i = '0;
        qrd_in_ready = 1'b0; qrd_out_valid = 1'b0;
        row_out_r = '0; row_out_i = '0;
        res_ready = 1'b0;
        err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(posedge clk); #1;

        run_matrix(0, 0, 0, 0, -1, -1, 1'b0);
        run_matrix(0, 1, 0, 0, -1, -1, 1'b0);
        repeat (4) run_matrix(1, 2, 1, 1, -1, -1, 1'b1);
        run_matrix(1, 2, 1, 1, 6, -1, 1'b1);
        run_matrix(1, 0, 1, 1, -1, 7, 1'b0);

        @(negedge clk);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
